// File: rtl/block_fetch.sv
// Purpose : fetch a J x K tile of a row-major matrix through one synchronous-read memory port, zero-padding outside the matrix.
// Latency : start accepted in cycle 0 -> block_valid in cycle J*K+RD_LAT+1; one read slot per cycle.
// Backpr. : tile held in HOLD until block_valid && block_ready; start ignored while busy (no queueing).
//
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   start + request fields        base_addr, start_row, start_col, num_rows, num_cols, transpose
//   mem_rd_en/addr/data           single read port, data returns RD_LAT cycles after mem_rd_en
//   block, block_valid, block_ready
//                                 flat tile output (element n at [n*DATA_W +: DATA_W]) and its handshake
//   busy                          fetch in progress or tile not yet accepted
module block_fetch #(
   parameter int DATA_W = 16,
   parameter int J      = 2,
   parameter int K      = 2,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [ADDR_W-1:0]       start_row,
   input  logic [ADDR_W-1:0]       start_col,
   input  logic [ADDR_W-1:0]       num_rows,
   input  logic [ADDR_W-1:0]       num_cols,
   input  logic                    transpose,
   output logic                    mem_rd_en,
   output logic [ADDR_W-1:0]       mem_rd_addr,
   input  logic [DATA_W-1:0]       mem_rd_data,
   output logic [J*K*DATA_W-1:0]   block,
   output logic                    block_valid,
   input  logic                    block_ready,
   output logic                    busy
);

   localparam int N  = J * K;
   localparam int DW = (N > 1)      ? $clog2(N)      : 1;
   localparam int IW = (J > 1)      ? $clog2(J)      : 1;
   localparam int JW = (K > 1)      ? $clog2(K)      : 1;
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [IW-1:0] I_LAST = IW'(J - 1);
   localparam logic [JW-1:0] J_LAST = JW'(K - 1);
   localparam logic [LW-1:0] L_LAST = LW'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] base;
      logic [ADDR_W-1:0] row;
      logic [ADDR_W-1:0] col;
      logic [ADDR_W-1:0] nrows;
      logic [ADDR_W-1:0] ncols;
      logic              tr;
   } req_t;

   state_t                    state_q, state_d;
   req_t                      req_q, req_d;
   logic [IW-1:0]             i_q, i_d;
   logic [JW-1:0]             j_q, j_d;
   logic [LW-1:0]             lat_q, lat_d;
   logic [N*DATA_W-1:0]       block_q, block_d;

   // Read-return pipeline: one stage per cycle of memory latency, carrying
   // the tile slot the returning word belongs to.
   logic [RD_LAT-1:0]         pipe_vld_q, pipe_vld_d;
   logic [RD_LAT-1:0]         pipe_oob_q, pipe_oob_d;
   logic [RD_LAT-1:0][DW-1:0] pipe_dest_q, pipe_dest_d;

   // Current issue slot decode
   logic                      accept;
   logic                      issuing;
   logic                      last_slot;
   logic [ADDR_W:0]           row_sum;
   logic [ADDR_W:0]           col_sum;
   logic                      in_bounds;
   logic [ADDR_W-1:0]         slot_addr;
   logic [DW-1:0]             slot_dest;

   always_comb begin
      accept    = (state_q == IDLE) && start;
      issuing   = (state_q == ISSUE);
      last_slot = (i_q == I_LAST) && (j_q == J_LAST);
      // One extra bit so a tile hanging off the top of the address range is
      // seen as out of bounds rather than wrapping back into the matrix.
      row_sum   = {1'b0, req_q.row} + (ADDR_W+1)'(i_q);
      col_sum   = {1'b0, req_q.col} + (ADDR_W+1)'(j_q);
      in_bounds = (row_sum < {1'b0, req_q.nrows}) && (col_sum < {1'b0, req_q.ncols});
      // Address arithmetic is deliberately modulo 2^ADDR_W.
      slot_addr = req_q.base + row_sum[ADDR_W-1:0] * req_q.ncols + col_sum[ADDR_W-1:0];
      slot_dest = req_q.tr ? DW'(int'(j_q) * J + int'(i_q))
                           : DW'(int'(i_q) * K + int'(j_q));
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start)            state_d = ISSUE;
         ISSUE: if (last_slot)        state_d = DRAIN;
         DRAIN: if (lat_q == L_LAST)  state_d = HOLD;
         HOLD:  if (block_ready)      state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      mem_rd_en   = issuing && in_bounds;
      mem_rd_addr = (issuing && in_bounds) ? slot_addr : '0;
      block_valid = (state_q == HOLD);
      busy        = (state_q != IDLE);
      block       = block_q;
   end

   // Datapath next-state
   always_comb begin
      req_d       = req_q;
      i_d         = i_q;
      j_d         = j_q;
      lat_d       = lat_q;
      block_d     = block_q;
      pipe_vld_d  = pipe_vld_q;
      pipe_oob_d  = pipe_oob_q;
      pipe_dest_d = pipe_dest_q;

      if (accept) begin
         req_d   = '{base:  base_addr, row:   start_row, col: start_col,
                     nrows: num_rows,  ncols: num_cols,  tr:  transpose};
         i_d     = '0;
         j_d     = '0;
         lat_d   = '0;
         block_d = '0;
      end

      if (issuing) begin
         if (j_q == J_LAST) begin
            j_d = '0;
            i_d = i_q + 1'b1;
         end else begin
            j_d = j_q + 1'b1;
         end
      end

      if (state_q == DRAIN) begin
         lat_d = lat_q + 1'b1;
      end

      // Out-of-bounds slots travel down the pipe too so every slot retires
      // in the same cycle it would have, keeping the drain length fixed.
      pipe_vld_d[0]  = issuing;
      pipe_oob_d[0]  = !in_bounds;
      pipe_dest_d[0] = slot_dest;
      for (int k = 1; k < RD_LAT; k++) begin
         pipe_vld_d[k]  = pipe_vld_q[k-1];
         pipe_oob_d[k]  = pipe_oob_q[k-1];
         pipe_dest_d[k] = pipe_dest_q[k-1];
      end

      if (pipe_vld_q[RD_LAT-1]) begin
         for (int n = 0; n < N; n++) begin
            if (pipe_dest_q[RD_LAT-1] == DW'(n)) begin
               block_d[n*DATA_W +: DATA_W] = pipe_oob_q[RD_LAT-1] ? '0 : mem_rd_data;
            end
         end
      end
   end

   // Datapath registers; reset also discards any reads still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q       <= '0;
         i_q         <= '0;
         j_q         <= '0;
         lat_q       <= '0;
         block_q     <= '0;
         pipe_vld_q  <= '0;
         pipe_oob_q  <= '0;
         pipe_dest_q <= '0;
      end else begin
         req_q       <= req_d;
         i_q         <= i_d;
         j_q         <= j_d;
         lat_q       <= lat_d;
         block_q     <= block_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_oob_q  <= pipe_oob_d;
         pipe_dest_q <= pipe_dest_d;
      end
   end

endmodule
